// File: rtl/down_timer_ctrl.sv
// Programmable down-counter sequencer: one-shot or auto-reload countdown with pause/stop,
// terminal-count pulse and done flag. Optional prescaler: define DOWN_TIMER_PRESCALE_EN.
module down_timer_ctrl #(
    parameter int WIDTH   = 4,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               mode,
    input  logic [WIDTH-1:0]   load_val,
`ifdef DOWN_TIMER_PRESCALE_EN
    input  logic [PRESC_W-1:0] presc,
`endif
    output logic [WIDTH-1:0]   count,
    output logic               busy,
    output logic               tc,
    output logic               done,
    output logic               err
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t             state, state_d;
    logic [WIDTH-1:0]   count_d, reload_reg, reload_d;
    logic               mode_reg, mode_d;
    logic               tc_d, err_d;
    logic [PRESC_W-1:0] p, p_d, p_rld;
    logic               tick, dec;

    // With the prescaler compiled out p reloads to zero, so tick is permanently 1.
`ifdef DOWN_TIMER_PRESCALE_EN
    assign p_rld = presc;
`else
    assign p_rld = '0;
`endif

    assign tick = (p == '0);
    assign dec  = (state == RUN) && !pause && tick;
    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state      <= IDLE;
            count      <= '0;
            reload_reg <= '0;
            mode_reg   <= 1'b0;
            p          <= '0;
            tc         <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_d;
            count      <= count_d;
            reload_reg <= reload_d;
            mode_reg   <= mode_d;
            p          <= p_d;
            tc         <= tc_d;
            err        <= err_d;
        end
    end

    always_comb begin
        state_d  = state;
        count_d  = count;
        reload_d = reload_reg;
        mode_d   = mode_reg;
        p_d      = p;
        tc_d     = 1'b0;
        err_d    = 1'b0;
        case (state)
            IDLE, DONE: begin
                p_d = '0;
                // stop outranks start: no load and no err when both are high
                if (stop) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (start) begin
                    if (load_val != '0) begin
                        count_d  = load_val;
                        reload_d = load_val;
                        mode_d   = mode;
                        p_d      = p_rld;
                        state_d  = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    count_d = '0;
                    p_d     = '0;
                end else if (dec) begin
                    p_d = p_rld;
                    if (count > WIDTH'(1)) begin
                        count_d = count - WIDTH'(1);
                    end else begin
                        tc_d = 1'b1;
                        if (mode_reg) begin
                            count_d = reload_reg;
                        end else begin
                            count_d = '0;
                            state_d = DONE;
                        end
                    end
                end else if (!pause) begin
                    p_d = p - PRESC_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
                p_d     = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_down_timer_ctrl.sv
// Scoreboard bench for down_timer_ctrl: expected per-cycle outputs are queued when a
// scenario drives its stimulus, then popped and compared one cycle at a time.
module tb_down_timer_ctrl;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       start, stop, pause, mode;
    logic [3:0] load_val;
    logic [3:0] count;
    logic       busy, tc, done, err;
`ifdef DOWN_TIMER_PRESCALE_EN
    logic [3:0] presc;
`endif

    typedef struct packed {
        logic [3:0] count;
        logic       busy;
        logic       tc;
        logic       done;
        logic       err;
    } obs_t;

    obs_t q[$];
    obs_t got, exp;
    int   checks = 0;
    int   passed = 0;

    down_timer_ctrl #(.WIDTH(4), .PRESC_W(4)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .stop(stop), .pause(pause),
        .mode(mode), .load_val(load_val),
`ifdef DOWN_TIMER_PRESCALE_EN
        .presc(presc),
`endif
        .count(count), .busy(busy), .tc(tc), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(int c, bit b, bit t, bit d, bit e);
        obs_t o;
        o.count = 4'(c);
        o.busy  = b;
        o.tc    = t;
        o.done  = d;
        o.err   = e;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.count = count;
        o.busy  = busy;
        o.tc    = tc;
        o.done  = done;
        o.err   = err;
        return o;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr_n = 1'b0; start = 0; stop = 0; pause = 0; mode = 0; load_val = 0;
`ifdef DOWN_TIMER_PRESCALE_EN
        presc = 0;
`endif
        repeat (2) cyc();
        q.push_back(mk(0, 0, 0, 0, 0));
        q.push_back(mk(0, 0, 0, 0, 0));
        for (int i = 0; i < 2; i++) begin
            if (i == 1) begin
                clr_n = 1'b1;
                cyc();
            end
            exp = q.pop_front(); got = sample(); checks++;
            if (got !== exp)
                $display("FAIL reset[%0d]: got c=%0d b%b t%b d%b e%b, want c=%0d b%b t%b d%b e%b", i,
                         got.count, got.busy, got.tc, got.done, got.err,
                         exp.count, exp.busy, exp.tc, exp.done, exp.err);
            else passed++;
        end
    endtask

    task automatic test_reset_midrun();
        q.push_back(mk(5, 1, 0, 0, 0));  // running with count 5
        q.push_back(mk(0, 0, 0, 0, 0));  // asynchronously cleared
        q.push_back(mk(0, 0, 0, 0, 0));  // first edge after release
        q.push_back(mk(0, 0, 0, 0, 0));  // still IDLE
        start = 1; mode = 0; load_val = 5;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                clr_n = 1'b0;
                #1;
            end else begin
                cyc();
            end
            start = 0;
            exp = q.pop_front(); got = sample(); checks++;
            if (got !== exp)
                $display("FAIL reset_midrun[%0d]: got c=%0d b%b t%b d%b e%b, want c=%0d b%b t%b d%b e%b", i,
                         got.count, got.busy, got.tc, got.done, got.err,
                         exp.count, exp.busy, exp.tc, exp.done, exp.err);
            else passed++;
            if (i == 1) clr_n = 1'b1;
        end
    endtask

    task automatic test_oneshot();
        q.push_back(mk(4, 1, 0, 0, 0));
        q.push_back(mk(3, 1, 0, 0, 0));
        q.push_back(mk(2, 1, 0, 0, 0));
        q.push_back(mk(1, 1, 0, 0, 0));
        q.push_back(mk(0, 0, 1, 1, 0));
        q.push_back(mk(0, 0, 0, 1, 0));
        q.push_back(mk(0, 0, 0, 1, 0));
        start = 1; mode = 0; load_val = 4;
        for (int i = 0; i < 7; i++) begin
            cyc();
            start = 0;
            exp = q.pop_front(); got = sample(); checks++;
            if (got !== exp)
                $display("FAIL oneshot[%0d]: got c=%0d b%b t%b d%b e%b, want c=%0d b%b t%b d%b e%b", i,
                         got.count, got.busy, got.tc, got.done, got.err,
                         exp.count, exp.busy, exp.tc, exp.done, exp.err);
            else passed++;
        end
    endtask

    // Starts from DONE; a start mid-run must be ignored, stop ends the run.
    task automatic test_autoreload();
        q.push_back(mk(3, 1, 0, 0, 0));
        q.push_back(mk(2, 1, 0, 0, 0));
        q.push_back(mk(1, 1, 0, 0, 0));
        q.push_back(mk(3, 1, 1, 0, 0));
        q.push_back(mk(2, 1, 0, 0, 0));
        q.push_back(mk(1, 1, 0, 0, 0));
        q.push_back(mk(3, 1, 1, 0, 0));
        q.push_back(mk(2, 1, 0, 0, 0));
        q.push_back(mk(0, 0, 0, 0, 0));
        start = 1; mode = 1; load_val = 3;
        for (int i = 0; i < 9; i++) begin
            cyc();
            start = 0; stop = 0;
            exp = q.pop_front(); got = sample(); checks++;
            if (got !== exp)
                $display("FAIL autoreload[%0d]: got c=%0d b%b t%b d%b e%b, want c=%0d b%b t%b d%b e%b", i,
                         got.count, got.busy, got.tc, got.done, got.err,
                         exp.count, exp.busy, exp.tc, exp.done, exp.err);
            else passed++;
            if (i == 3) begin start = 1; load_val = 9; end
            if (i == 7) stop = 1;
        end
    endtask

    task automatic test_pause();
        q.push_back(mk(5, 1, 0, 0, 0));
        q.push_back(mk(4, 1, 0, 0, 0));
        q.push_back(mk(3, 1, 0, 0, 0));
        q.push_back(mk(3, 1, 0, 0, 0));
        q.push_back(mk(3, 1, 0, 0, 0));
        q.push_back(mk(3, 1, 0, 0, 0));
        q.push_back(mk(2, 1, 0, 0, 0));
        q.push_back(mk(1, 1, 0, 0, 0));
        q.push_back(mk(0, 0, 1, 1, 0));
        q.push_back(mk(0, 0, 0, 1, 0));
        start = 1; mode = 0; load_val = 5;
        for (int i = 0; i < 10; i++) begin
            cyc();
            start = 0;
            exp = q.pop_front(); got = sample(); checks++;
            if (got !== exp)
                $display("FAIL pause[%0d]: got c=%0d b%b t%b d%b e%b, want c=%0d b%b t%b d%b e%b", i,
                         got.count, got.busy, got.tc, got.done, got.err,
                         exp.count, exp.busy, exp.tc, exp.done, exp.err);
            else passed++;
            if (i == 2) pause = 1;
            if (i == 5) pause = 0;
        end
    endtask

    // Zero-load rejects (from DONE and IDLE), stop in DONE, start+stop, stop at count==1.
    task automatic test_boundary();
        q.push_back(mk(0, 0, 0, 1, 1));
        q.push_back(mk(0, 0, 0, 1, 0));
        q.push_back(mk(0, 0, 0, 0, 0));
        q.push_back(mk(0, 0, 0, 0, 1));
        q.push_back(mk(0, 0, 0, 0, 0));
        q.push_back(mk(0, 0, 0, 0, 0));
        q.push_back(mk(2, 1, 0, 0, 0));
        q.push_back(mk(1, 1, 0, 0, 0));
        q.push_back(mk(0, 0, 0, 0, 0));
        q.push_back(mk(0, 0, 0, 0, 0));
        start = 1; mode = 0; load_val = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            start = 0; stop = 0;
            exp = q.pop_front(); got = sample(); checks++;
            if (got !== exp)
                $display("FAIL boundary[%0d]: got c=%0d b%b t%b d%b e%b, want c=%0d b%b t%b d%b e%b", i,
                         got.count, got.busy, got.tc, got.done, got.err,
                         exp.count, exp.busy, exp.tc, exp.done, exp.err);
            else passed++;
            case (i)
                1: stop = 1;
                2: begin start = 1; load_val = 0; end
                3: begin start = 1; stop = 1; load_val = 4; end
                5: begin start = 1; load_val = 2; mode = 0; end
                7: stop = 1;
                default: ;
            endcase
        end
    endtask

    // Restart straight from DONE, then auto-reload with L=1 (tc every cycle).
    task automatic test_back_to_back();
        q.push_back(mk(1, 1, 0, 0, 0));
        q.push_back(mk(0, 0, 1, 1, 0));
        q.push_back(mk(2, 1, 0, 0, 0));
        q.push_back(mk(1, 1, 0, 0, 0));
        q.push_back(mk(0, 0, 1, 1, 0));
        q.push_back(mk(1, 1, 0, 0, 0));
        q.push_back(mk(1, 1, 1, 0, 0));
        q.push_back(mk(1, 1, 1, 0, 0));
        q.push_back(mk(0, 0, 0, 0, 0));
        start = 1; mode = 0; load_val = 1;
        for (int i = 0; i < 9; i++) begin
            cyc();
            start = 0; stop = 0;
            exp = q.pop_front(); got = sample(); checks++;
            if (got !== exp)
                $display("FAIL back_to_back[%0d]: got c=%0d b%b t%b d%b e%b, want c=%0d b%b t%b d%b e%b", i,
                         got.count, got.busy, got.tc, got.done, got.err,
                         exp.count, exp.busy, exp.tc, exp.done, exp.err);
            else passed++;
            case (i)
                1: begin start = 1; load_val = 2; end
                4: begin start = 1; load_val = 1; mode = 1; end
                7: stop = 1;
                default: ;
            endcase
        end
        mode = 0;
    endtask

`ifdef DOWN_TIMER_PRESCALE_EN
    task automatic test_prescale();
        q.push_back(mk(2, 1, 0, 0, 0));
        q.push_back(mk(2, 1, 0, 0, 0));
        q.push_back(mk(2, 1, 0, 0, 0));
        q.push_back(mk(1, 1, 0, 0, 0));
        q.push_back(mk(1, 1, 0, 0, 0));
        q.push_back(mk(1, 1, 0, 0, 0));
        q.push_back(mk(0, 0, 1, 1, 0));
        q.push_back(mk(0, 0, 0, 1, 0));
        presc = 2; start = 1; mode = 0; load_val = 2;
        for (int i = 0; i < 8; i++) begin
            cyc();
            start = 0;
            exp = q.pop_front(); got = sample(); checks++;
            if (got !== exp)
                $display("FAIL prescale[%0d]: got c=%0d b%b t%b d%b e%b, want c=%0d b%b t%b d%b e%b", i,
                         got.count, got.busy, got.tc, got.done, got.err,
                         exp.count, exp.busy, exp.tc, exp.done, exp.err);
            else passed++;
        end
        presc = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_reset_midrun();
        test_oneshot();
        test_autoreload();
        test_pause();
        test_boundary();
        test_back_to_back();
`ifdef DOWN_TIMER_PRESCALE_EN
        test_prescale();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/down_timer_ctrl.md
Name: down_timer_ctrl

Overview:
Sequencing controller for a synchronous down-counter datapath. It loads a start value, counts down in a single-shot or auto-reload mode, and supports pause and stop. It raises a one-cycle terminal-count pulse and holds a done flag. It sits between a host/register interface and any logic that needs a programmable countdown, such as timers, watchdogs and periodic event generators.

Parameters:
WIDTH, 4, bit width of the load value and the down-count register.
PRESC_W, 4, bit width of the prescaler (used only when the optional feature is compiled in).

Ports:
clk  input  1  rising-edge clock.
clr_n  input  1  asynchronous active-low reset.
start  input  1  request to load and run; sampled each rising edge.
stop  input  1  abort a run and return to IDLE.
pause  input  1  level; freezes the count while high.
mode  input  1  0 = one-shot, 1 = auto-reload; sampled with an accepted start.
load_val  input  WIDTH  start count; sampled with an accepted start.
count  output  WIDTH  current count value (registered).
busy  output  1  high while state is RUN.
tc  output  1  one-cycle terminal-count pulse (registered).
done  output  1  high in state DONE (one-shot finished).
err  output  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset (clr_n low, asynchronous): state=IDLE; count, reload_reg, mode_reg, tc, done, busy and err all 0. Release is synchronous to the next clk edge.
- States: IDLE, RUN, DONE. Encoding is free; no illegal state may lock up, and any unused encoding goes to IDLE.
- Decrement enable: dec = (state==RUN) & ~pause & tick. Without the optional feature, tick=1.
- Start acceptance (IDLE or DONE only), when start=1, stop=0 and load_val!=0:
  - count<=load_val, reload_reg<=load_val, mode_reg<=mode.
  - state->RUN, done<=0.
- Start with load_val==0 is rejected: state unchanged, err=1 for one cycle.
- Start in RUN is ignored (no reload, no err).
- In RUN with dec=1 and count>1: count<=count-1.
- In RUN with dec=1 and count==1:
  - tc<=1 for one cycle.
  - mode_reg=0: count<=0, state->DONE.
  - mode_reg=1: count<=reload_reg, stay in RUN.
  - Result: the first tc occurs L ticks after the start edge (L=load_val); the auto-reload period is L ticks.
- tc defaults to 0 on every edge where it is not set.
- Pause: count held, no tc, busy stays 1. Releasing pause resumes decrementing on the next edge.
- Stop in RUN: state->IDLE, count<=0, busy<=0, no tc. Stop beats a terminal-count event in the same cycle.
- Stop in DONE: state->IDLE, done<=0.
- start and stop together: stop wins; start is not accepted and err is not raised.
- DONE holds count=0 and done=1 until an accepted start or a stop.
- busy = (state==RUN); done = (state==DONE).
- Reset mid-run aborts immediately to the reset values.

Optional Feature:
DOWN_TIMER_PRESCALE_EN.
- Defined:
  - Adds input presc[PRESC_W-1:0] and an internal prescaler counter p.
  - tick=1 when p==0. On a tick edge with state RUN and ~pause, p<=presc; otherwise, in RUN with ~pause, p decrements.
  - On an accepted start, p<=presc.
  - p is held during pause and cleared to 0 in IDLE, DONE and on reset.
  - Net effect: the count decrements once every presc+1 cycles.
- Undefined: no presc port, tick=1, and the count decrements every RUN cycle.

Test Plan:
- Reset mid-run: reset asserted with count=5 in RUN -> count=0, busy=0, tc=0, done=0 immediately; IDLE after release.
- One-shot: mode=0, load_val=4, start pulse -> count 4,3,2,1,0 on successive edges; tc=1 for exactly the cycle count=0 is first shown; done=1; busy=0.
- Auto-reload: mode=1, load_val=3 -> count 3,2,1,3,2,1,3…; tc pulses every 3 cycles; done stays 0.
- Pause: load_val=5, pause high 3 cycles while count=3 -> count holds 3; resumes 2,1,0; tc is delayed by exactly 3 cycles.
- Boundary starts: load_val=0 start -> err=1 for one cycle, stays IDLE. start+stop together -> no run. Stop on the cycle count==1 -> IDLE, no tc.
- With DOWN_TIMER_PRESCALE_EN: presc=2, load_val=2, one-shot -> count changes every 3 cycles; tc 6 cycles after the start edge.
